fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 48 ++++
 rtl/fetch_queue.sv | 141 ++++++++++++++
 tb/tb_fetch_queue.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
//   Bundles every non-clock, non-reset signal of the fetch queue.
//
//   Control   : start, FirstInstAdd (boot address), redirect_valid/redirect_pc
//   Memory    : req_valid/req_addr/req_ready (request channel),
//               rsp_valid/rsp_data (in-order return channel)
//   Decode    : inst_valid/inst/inst_pc/inst_ready (head of the queue)
//   Status    : busy
//
//   master : the fetch_queue side (drives requests, head entry and busy)
//   slave  : the environment (core control, instruction memory, decode)
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int XLEN       = 32,
    parameter int INST_WIDTH = 32
);
    logic                  start;
    logic [XLEN-1:0]       FirstInstAdd;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;

    logic                  req_valid;
    logic [XLEN-1:0]       req_addr;
    logic                  req_ready;

    logic                  rsp_valid;
    logic [INST_WIDTH-1:0] rsp_data;

    logic                  inst_valid;
    logic [INST_WIDTH-1:0] inst;
    logic [XLEN-1:0]       inst_pc;
    logic                  inst_ready;

    logic                  busy;

    modport master (
        input  start, FirstInstAdd, redirect_valid, redirect_pc,
        input  req_ready, rsp_valid, rsp_data, inst_ready,
        output req_valid, req_addr, inst_valid, inst, inst_pc, busy
    );

    modport slave (
        output start, FirstInstAdd, redirect_valid, redirect_pc,
        output req_ready, rsp_valid, rsp_data, inst_ready,
        input  req_valid, req_addr, inst_valid, inst, inst_pc, busy
    );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch unit with a small in-order instruction queue.
//   After a start pulse it issues sequential fetch requests (pc += 4) to an
//   instruction memory whose responses come back in request order with a
//   latency of one or more cycles. Returned instructions are queued together
//   with their PC and presented to decode from the queue head. A redirect
//   flushes the queue, reloads the fetch PC and, if responses are still in
//   flight, waits in FLUSH discarding them before fetching again.
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   rstn  : asynchronous active-low reset
//   fq    : fetch_queue_if.master (control, memory, decode and busy signals)
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int XLEN       = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic          clk,
    input  logic          rstn,
    fetch_queue_if.master fq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_CNT = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t          state_reg;
    logic [XLEN-1:0] fetch_pc_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   occupancy_reg;
    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;

    // Queue storage: small register file with a combinational head read.
    logic [INST_WIDTH-1:0] entry_data [DEPTH];
    logic [XLEN-1:0]       entry_pc   [DEPTH];

    logic            in_run;
    logic [CW:0]     reserved;
    logic            req_fire;
    logic            rsp_live;
    logic            rsp_push;
    logic            pop_fire;
    logic [CW-1:0]   outstanding_after_rsp;
    logic [XLEN-1:0] rsp_pc;

    assign in_run = (state_reg == ST_RUN);

    // Slots are reserved when a request is accepted, so the queue can never
    // overflow: entries already held plus responses still owed must fit.
    assign reserved     = {1'b0, occupancy_reg} + {1'b0, outstanding_reg};
    assign fq.req_valid = in_run && !fq.redirect_valid && (reserved < DEPTH_CNT);
    assign fq.req_addr  = fetch_pc_reg;
    assign req_fire     = fq.req_valid && fq.req_ready;

    // A response only means something when one is owed; in IDLE (e.g. a late
    // return after a reset) it is ignored entirely.
    assign rsp_live = fq.rsp_valid && (state_reg != ST_IDLE) && (outstanding_reg != '0);
    assign rsp_push = rsp_live && in_run && !fq.redirect_valid;
    assign outstanding_after_rsp = outstanding_reg - CW'(rsp_live);

    // Requests are issued at consecutive PCs and never mix across a redirect
    // (FLUSH drains first), so the oldest outstanding request sits
    // outstanding*4 bytes behind the current fetch PC.
    assign rsp_pc = fetch_pc_reg - XLEN'({outstanding_reg, 2'b00});

    assign fq.inst_valid = (occupancy_reg != '0);
    assign pop_fire      = fq.inst_valid && fq.inst_ready;
    assign fq.inst       = fq.inst_valid ? entry_data[head_reg] : '0;
    assign fq.inst_pc    = fq.inst_valid ? entry_pc[head_reg]   : '0;
    assign fq.busy       = (state_reg != ST_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= ST_IDLE;
            fetch_pc_reg    <= '0;
            outstanding_reg <= '0;
            occupancy_reg   <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
        end else if (fq.redirect_valid) begin
            // Redirect wins in every state, including over start in IDLE.
            // A same-cycle pop is simply absorbed by the clear.
            fetch_pc_reg    <= fq.redirect_pc;
            occupancy_reg   <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
            outstanding_reg <= outstanding_after_rsp;
            state_reg       <= (outstanding_after_rsp != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (fq.start) begin
                        state_reg    <= ST_RUN;
                        fetch_pc_reg <= fq.FirstInstAdd;
                    end
                end
                ST_RUN: begin
                    if (req_fire) begin
                        fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
                    end
                    outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(rsp_live);
                    occupancy_reg   <= occupancy_reg + CW'(rsp_push) - CW'(pop_fire);
                    if (rsp_push) begin
                        tail_reg <= tail_reg + PW'(1);
                    end
                    if (pop_fire) begin
                        head_reg <= head_reg + PW'(1);
                    end
                end
                ST_FLUSH: begin
                    // Stale responses are dropped; fetching resumes from the
                    // redirected PC once the last one has gone by.
                    outstanding_reg <= outstanding_after_rsp;
                    if (outstanding_after_rsp == '0) begin
                        state_reg <= ST_RUN;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Entry contents need no reset: they are only visible while occupied.
    always_ff @(posedge clk) begin
        if (rsp_push) begin
            entry_data[tail_reg] <= fq.rsp_data;
            entry_pc[tail_reg]   <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//   Directed bench for fetch_queue. Keeps a queue-based model of the fetch
//   unit and an in-order instruction memory with programmable latency; DUT
//   outputs are compared to the model every cycle, and literal expectations
//   pin the model for each scenario.
// ---------------------------------------------------------------------------
module tb_fetch_queue;
    localparam int XLEN  = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 4;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_FLUSH = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    fetch_queue_if #(.XLEN(XLEN), .INST_WIDTH(IW)) bus ();

    fetch_queue #(
        .XLEN      (XLEN),
        .INST_WIDTH(IW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .fq  (bus)
    );

    always #5 clk = ~clk;

    // model state
    int              m_state = S_IDLE;
    logic [XLEN-1:0] m_pc    = '0;
    logic [XLEN-1:0] out_q[$];       // PCs of requests still owed a response
    logic [XLEN-1:0] ent_pc_q[$];    // queued entries, program order
    logic [IW-1:0]   ent_data_q[$];

    // instruction memory
    logic [XLEN-1:0] mem_addr_q[$];
    int              mem_due_q[$];
    int              lat = 1;

    // logs and counters
    logic [XLEN-1:0] acc_log[$];
    int              acc_cyc_log[$];
    logic [XLEN-1:0] pop_log[$];
    int              pop_cyc_log[$];
    int              drop_count = 0;
    int              cyc        = 0;
    int              vectors    = 0;
    int              miscompares = 0;

    logic            seen_req_valid;
    logic [XLEN-1:0] seen_req_addr;
    logic            seen_inst_valid;

    function automatic logic [IW-1:0] mem_word(input logic [XLEN-1:0] addr);
        return IW'(addr ^ 32'hA5A5_5A5A);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        acc_log.delete();
        acc_cyc_log.delete();
        pop_log.delete();
        pop_cyc_log.delete();
    endtask

    // One clock cycle: entered just after a falling edge with inputs set.
    task automatic step(input bit reset_mid = 1'b0);
        logic            rsp;
        logic [IW-1:0]   rdata;
        logic [XLEN-1:0] tmp_addr;
        logic [XLEN-1:0] pc;
        int              tmp_due;
        logic            exp_rv;
        logic            exp_iv;
        logic            acc;
        logic            pop;

        rdata = '0;
        rsp   = (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc);
        if (rsp) begin
            tmp_addr = mem_addr_q.pop_front();
            tmp_due  = mem_due_q.pop_front();
            rdata    = mem_word(tmp_addr);
        end
        bus.rsp_valid = rsp;
        bus.rsp_data  = rdata;
        if (rsp && rstn && m_state != S_IDLE)
            check("rsp_protocol", 64'(out_q.size() > 0), 64'd1);

        #1;
        exp_rv = rstn && (m_state == S_RUN) && !bus.redirect_valid &&
                 (ent_pc_q.size() + out_q.size() < DEPTH);
        exp_iv = ent_pc_q.size() > 0;
        check("req_valid",  bus.req_valid,  exp_rv);
        check("req_addr",   bus.req_addr,   m_pc);
        check("inst_valid", bus.inst_valid, exp_iv);
        check("inst",       bus.inst,       exp_iv ? ent_data_q[0] : '0);
        check("inst_pc",    bus.inst_pc,    exp_iv ? ent_pc_q[0] : '0);
        check("busy",       bus.busy,       m_state != S_IDLE);
        seen_req_valid  = bus.req_valid;
        seen_req_addr   = bus.req_addr;
        seen_inst_valid = bus.inst_valid;

        if (reset_mid) begin
            #2;
            rstn = 1'b0;
            #1;
            check("rst_req_valid",  bus.req_valid,  0);
            check("rst_req_addr",   bus.req_addr,   0);
            check("rst_inst_valid", bus.inst_valid, 0);
            check("rst_inst",       bus.inst,       0);
            check("rst_inst_pc",    bus.inst_pc,    0);
            check("rst_busy",       bus.busy,       0);
        end

        @(posedge clk);
        acc = rstn && exp_rv && bus.req_ready;
        pop = rstn && exp_iv && bus.inst_ready;
        if (!rstn) begin
            m_state = S_IDLE;
            m_pc    = '0;
            out_q.delete();
            ent_pc_q.delete();
            ent_data_q.delete();
        end else begin
            if (acc) begin
                acc_log.push_back(m_pc);
                acc_cyc_log.push_back(cyc);
                mem_addr_q.push_back(m_pc);
                mem_due_q.push_back(cyc + lat);
            end
            if (pop) begin
                pop_log.push_back(ent_pc_q[0]);
                pop_cyc_log.push_back(cyc);
            end
            if (bus.redirect_valid) begin
                if (rsp && out_q.size() > 0) begin
                    pc = out_q.pop_front();
                    drop_count++;
                end
                ent_pc_q.delete();
                ent_data_q.delete();
                m_pc    = bus.redirect_pc;
                m_state = (out_q.size() > 0) ? S_FLUSH : S_RUN;
            end else begin
                case (m_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            m_state = S_RUN;
                            m_pc    = bus.FirstInstAdd;
                        end
                    end
                    S_RUN: begin
                        if (pop) begin
                            pc = ent_pc_q.pop_front();
                            rdata = ent_data_q.pop_front();
                        end
                        if (rsp && out_q.size() > 0) begin
                            pc = out_q.pop_front();
                            ent_pc_q.push_back(pc);
                            ent_data_q.push_back(bus.rsp_data);
                        end
                        if (acc) begin
                            out_q.push_back(m_pc);
                            m_pc = m_pc + 32'd4;
                        end
                    end
                    default: begin
                        if (rsp && out_q.size() > 0) begin
                            pc = out_q.pop_front();
                            drop_count++;
                            if (out_q.size() == 0) m_state = S_RUN;
                        end
                    end
                endcase
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int p0;

        bus.start          = 1'b0;
        bus.FirstInstAdd   = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.req_ready      = 1'b1;
        bus.rsp_valid      = 1'b0;
        bus.rsp_data       = '0;
        bus.inst_ready     = 1'b1;

        // reset and idle
        repeat (3) step();
        rstn = 1'b1;
        repeat (2) step();
        check("idle_req_valid",  bus.req_valid,  0);
        check("idle_req_addr",   bus.req_addr,   0);
        check("idle_inst_valid", bus.inst_valid, 0);
        check("idle_busy",       bus.busy,       0);

        // start at 0x1000, 1-cycle memory, decode always ready
        bus.FirstInstAdd = 32'h0000_1000;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        clear_logs();
        repeat (10) step();
        check("s37_acc0", acc_log[0], 32'h1000);
        check("s37_acc1", acc_log[1], 32'h1004);
        check("s37_acc3", acc_log[3], 32'h100C);
        check("s37_acc_back_to_back", acc_cyc_log[3] - acc_cyc_log[0], 3);
        check("s37_pop0", pop_log[0], 32'h1000);
        check("s37_pop1", pop_log[1], 32'h1004);
        check("s37_req_to_inst", pop_cyc_log[0] - acc_cyc_log[0], 2);
        check("s37_no_bubbles", pop_cyc_log[5] - pop_cyc_log[0], 5);

        // stall decode: exactly DEPTH requests then req_valid drops
        bus.inst_ready     = 1'b0;
        bus.redirect_pc    = 32'h0000_3000;
        bus.redirect_valid = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        clear_logs();
        repeat (10) step();
        check("s38_acc_count", acc_log.size(), 4);
        check("s38_req_stalled", bus.req_valid, 0);
        check("s38_head_valid", bus.inst_valid, 1);
        check("s38_head_pc", bus.inst_pc, 32'h3000);
        check("s38_head_inst", bus.inst, 32'h3000 ^ 32'hA5A5_5A5A);
        bus.inst_ready = 1'b1;
        clear_logs();
        repeat (8) step();
        check("s38_drain0", pop_log[0], 32'h3000);
        check("s38_drain1", pop_log[1], 32'h3004);
        check("s38_drain2", pop_log[2], 32'h3008);
        check("s38_drain3", pop_log[3], 32'h300C);
        check("s38_drain4", pop_log[4], 32'h3010);
        check("s38_resume", acc_log[0], 32'h3010);

        // redirect together with a pop and a response
        check("s41_pre_inst_valid", bus.inst_valid, 1);
        p0 = pop_log.size();
        d0 = drop_count;
        bus.redirect_pc    = 32'h0000_4000;
        bus.redirect_valid = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        check("s41_req_valid_in_redirect", seen_req_valid, 0);
        check("s41_pop_counted", pop_log.size() - p0, 1);
        check("s41_rsp_dropped", drop_count - d0, 1);
        step();
        check("s41_inst_valid_after", seen_inst_valid, 0);
        check("s41_req_valid_after", seen_req_valid, 1);
        check("s41_req_addr_after", seen_req_addr, 32'h4000);

        // address wrap
        clear_logs();
        bus.redirect_pc    = 32'hFFFF_FFF8;
        bus.redirect_valid = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        repeat (6) step();
        check("s40_acc0", acc_log[0], 32'hFFFF_FFF8);
        check("s40_acc1", acc_log[1], 32'hFFFF_FFFC);
        check("s40_acc2", acc_log[2], 32'h0000_0000);
        check("s40_pop2", pop_log[2], 32'h0000_0000);

        // 3-cycle memory, redirect with 3 outstanding -> FLUSH
        lat = 3;
        n = 0;
        while (out_q.size() != 3 && n < 20) begin
            step();
            n++;
        end
        check("s39_three_outstanding", out_q.size(), 3);
        d0 = drop_count;
        clear_logs();
        bus.redirect_pc    = 32'h0000_2000;
        bus.redirect_valid = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        check("s39_in_flush", m_state, S_FLUSH);
        check("s39_flush_no_req", bus.req_valid, 0);
        check("s39_flush_busy", bus.busy, 1);
        repeat (10) step();
        check("s39_drops", drop_count - d0, 3);
        check("s39_first_req", acc_log[0], 32'h2000);
        check("s39_first_inst_pc", pop_log[0], 32'h2000);

        // reset with entries queued and 2 requests outstanding
        bus.inst_ready = 1'b0;
        n = 0;
        while (!(out_q.size() == 2 && ent_pc_q.size() >= 2) && n < 30) begin
            step();
            n++;
        end
        check("s42_setup", out_q.size(), 2);
        step(1'b1);
        rstn = 1'b1;
        bus.inst_ready = 1'b1;
        repeat (6) step();
        check("s42_late_rsp_ignored", bus.inst_valid, 0);
        check("s42_idle_req_valid", bus.req_valid, 0);
        check("s42_idle_busy", bus.busy, 0);

        // restart after reset with a throttled memory request port
        lat = 2;
        clear_logs();
        bus.FirstInstAdd = 32'h0000_8000;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.req_ready = (i % 3) != 1;
            step();
        end
        bus.req_ready = 1'b1;
        repeat (6) step();
        check("restart_acc0", acc_log[0], 32'h8000);
        check("restart_acc1", acc_log[1], 32'h8004);
        check("restart_pop0", pop_log[0], 32'h8000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
